// File: rtl/circular_buffer_write_packer_if.sv
// circular_buffer_write_packer_if: upstream element stream plus circular-buffer write port and stats
interface circular_buffer_write_packer_if #(
  parameter int ROW_SIZE   = 8,
  parameter int PAR_WRITE  = 4,
  parameter int STAT_WIDTH = 16
);
  logic                          in_valid;
  logic [ROW_SIZE-1:0]           in_data;
  logic                          in_last;
  logic                          in_ready;
  logic                          buf_full;
  logic                          buf_wen;
  logic                          buf_update_wp;
  logic [ROW_SIZE*PAR_WRITE-1:0] buf_din;
  logic [STAT_WIDTH-1:0]         words_written;
  logic [STAT_WIDTH-1:0]         stall_cycles;
  modport master (
    input  in_valid, in_data, in_last, buf_full,
    output in_ready, buf_wen, buf_update_wp, buf_din, words_written, stall_cycles
  );
  modport slave (
    output in_valid, in_data, in_last, buf_full,
    input  in_ready, buf_wen, buf_update_wp, buf_din, words_written, stall_cycles
  );
endinterface

// File: rtl/circular_buffer_write_packer.sv
// circular_buffer_write_packer: packs PAR_WRITE elements into one buffer write word.
// Optional saturating statistics counters are built when PACKER_STATS_EN is defined.
module circular_buffer_write_packer #(
  parameter int                    ROW_SIZE   = 8,
  parameter int                    PAR_WRITE  = 4,
  parameter logic [ROW_SIZE-1:0]   PAD_VALUE  = '0,
  parameter int                    STAT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  circular_buffer_write_packer_if.master bus
);
  localparam int CW = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [ROW_SIZE*PAR_WRITE-1:0] PAD_WORD = {PAR_WRITE{PAD_VALUE}};
  typedef enum logic {FILL, PUSH} state_t;
  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [ROW_SIZE*PAR_WRITE-1:0] lanes_q, lanes_d;
  logic                          accept, wen;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    accept  = (state_q == FILL) && bus.in_valid;
    wen     = (state_q == PUSH) && !bus.buf_full;
    if (accept) begin
      lanes_d[int'(cnt_q)*ROW_SIZE +: ROW_SIZE] = bus.in_data;
      state_d = (cnt_q == CW'(PAR_WRITE-1) || bus.in_last) ? PUSH : FILL;
      cnt_d   = (cnt_q == CW'(PAR_WRITE-1) || bus.in_last) ? '0 : cnt_q + CW'(1);
    end
    if (wen) begin
      state_d = FILL;
      lanes_d = PAD_WORD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      lanes_q <= PAD_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end
  assign bus.in_ready      = (state_q == FILL);
  assign bus.buf_wen       = wen;
  assign bus.buf_update_wp = wen;
  assign bus.buf_din       = lanes_q;
`ifdef PACKER_STATS_EN
  logic [STAT_WIDTH-1:0] words_q, words_d, stall_q, stall_d;
  always_comb begin
    words_d = (wen && !(&words_q)) ? words_q + STAT_WIDTH'(1) : words_q;
    stall_d = (state_q == PUSH && bus.buf_full && !(&stall_q)) ? stall_q + STAT_WIDTH'(1) : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end
  assign bus.words_written = words_q;
  assign bus.stall_cycles  = stall_q;
`else
  assign bus.words_written = '0;
  assign bus.stall_cycles  = '0;
`endif
endmodule
